lc4_multiplier_seq: RTL

//   Iterative unsigned shift-add multiplier for the LC4 datapath. It is the inverse

---
 rtl/lc4_multiplier_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/lc4_multiplier_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit retired per clock.
// Optional early termination when the remaining multiplier bits are zero: LC4_MUL_EARLY_TERM_EN.
module lc4_multiplier_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_valid,
    input  logic               i_result_ready,
    output logic [WIDTH-1:0]   o_product_lo,
    output logic [WIDTH-1:0]   o_product_hi
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     mplier_next;
    logic [CNT_W-1:0]     cnt;
    logic                 last_step;

    // The top half of mcand starts at zero, so the 2*WIDTH-bit sum never overflows.
    always_comb begin
        mplier_next = mplier >> 1;
        acc_next    = mplier[0] ? (acc + mcand) : acc;
`ifdef LC4_MUL_EARLY_TERM_EN
        last_step   = (cnt == CNT_W'(1)) || (mplier_next == '0);
`else
        last_step   = (cnt == CNT_W'(1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_valid) begin
`ifdef LC4_MUL_EARLY_TERM_EN
                    next_state = (i_multiplier == '0) ? S_DONE : S_BUSY;
`else
                    next_state = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                if (last_step) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_result_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
                        mplier <= i_multiplier;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                    end
                end
                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_ready      = (state == S_IDLE);
    assign o_valid      = (state == S_DONE);
    assign o_product_lo = acc[WIDTH-1:0];
    assign o_product_hi = acc[2*WIDTH-1:WIDTH];

endmodule
